duv_event_logger: RTL and testbench

- Downstream consumer of the DUV's four 2-bit outputs (out_a..out_d).
- Compares the 8-bit concatenation {obs_d, obs_c, obs_b, obs_a} against the last logged value every cycle.
- On a change, pushes an event word (sample plus timestamp) into a show-ahead FIFO.
- Events are drained through a valid/ready port by the bench or a later checker; overflow is flagged sticky and counted.

---
 rtl/duv_event_logger.sv | 116 +++++++++++
 tb/tb_duv_event_logger.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/duv_event_logger.sv
// Event logger: timestamps changes on the four 2-bit DUV outputs into a FIFO.
// Ports: clk, arst (sync, active-high), en, obs_a..obs_d in; ev_valid/ev_ready/
//   ev_data/ev_ts head port; level occupancy; ovf sticky flag, ovf_clr, drop_cnt.
// Optional: define DUV_EVENT_LOGGER_TIMESTAMP_EN to store and report timestamps;
//   otherwise entries are 8 bits and ev_ts is tied to zero.
module duv_event_logger #(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     en,
    input  logic [1:0]               obs_a,
    input  logic [1:0]               obs_b,
    input  logic [1:0]               obs_c,
    input  logic [1:0]               obs_d,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [7:0]               ev_data,
    output logic [TS_W-1:0]          ev_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef DUV_EVENT_LOGGER_TIMESTAMP_EN
    localparam int EW = 8 + TS_W;
`else
    localparam int EW = 8;
`endif

    logic [7:0]    cur;
    logic [7:0]    prev;
    logic          chg;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;

    assign cur = {obs_d, obs_c, obs_b, obs_a};
    assign chg = en && (cur != prev);
    assign pop = ev_valid && ev_ready;

    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok = chg && ((level_q < LW'(DEPTH)) || pop);
    assign drop    = chg && !push_ok;

`ifdef DUV_EVENT_LOGGER_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk) begin
        if (arst) ts <= '0;
        else      ts <= ts + TS_W'(1);
    end

    assign entry = {ts, cur};
    assign ev_ts = ev_valid ? head[EW-1:8] : '0;
`else
    assign entry = cur;
    assign ev_ts = '0;
`endif

    assign head     = mem[rd_ptr];
    assign ev_valid = (level_q != '0);
    assign ev_data  = ev_valid ? head[7:0] : 8'h00;
    assign level    = level_q;

    // Storage carries no reset; the head is masked by level while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            prev    <= 8'h00;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            // Dropped values also update prev so they are not re-reported.
            if (chg)     prev   <= cur;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clr wins and restarts the count at 1.
    always_ff @(posedge clk) begin
        if (arst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr)              drop_cnt <= DROP_W'(1);
            else if (drop_cnt != '1)  drop_cnt <= drop_cnt + DROP_W'(1);
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_duv_event_logger.sv
// Directed self-checking bench for duv_event_logger.
// Expected timestamps follow DUV_EVENT_LOGGER_TIMESTAMP_EN (zero when undefined).
module tb_duv_event_logger;

    logic        clk = 1'b0;
    logic        arst;
    logic        en;
    logic [1:0]  obs_a, obs_b, obs_c, obs_d;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_data;
    logic [15:0] ev_ts;
    logic [3:0]  level;
    logic        ovf;
    logic        ovf_clr;
    logic [7:0]  drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    duv_event_logger #(.DEPTH(8), .TS_W(16), .DROP_W(8)) dut (
        .clk(clk), .arst(arst), .en(en),
        .obs_a(obs_a), .obs_b(obs_b), .obs_c(obs_c), .obs_d(obs_d),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .ev_ts(ev_ts), .level(level), .ovf(ovf), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [7:0] v);
        {obs_d, obs_c, obs_b, obs_a} = v;
    endtask

    function automatic logic [31:0] ts_exp(input int v);
`ifdef DUV_EVENT_LOGGER_TIMESTAMP_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b0; en = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
        set_cur(8'h00);

        // Reset state
        do_reset();
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_data", 32'(ev_data), 0);
        chk("rst_ts", 32'(ev_ts), 0);

        // Idle: no change for 10 cycles
        repeat (10) tick();
        chk("idle_valid", 32'(ev_valid), 0);
        chk("idle_level", 32'(level), 0);
        chk("idle_ovf", 32'(ovf), 0);

        // Single event captured at ts=3
        do_reset();
        repeat (3) tick();
        set_cur(8'h01);
        tick();
        chk("one_valid", 32'(ev_valid), 1);
        chk("one_data", 32'(ev_data), 32'h01);
        chk("one_ts", 32'(ev_ts), ts_exp(3));
        chk("one_level", 32'(level), 1);
        repeat (5) tick();
        chk("hold_data", 32'(ev_data), 32'h01);
        chk("hold_ts", 32'(ev_ts), ts_exp(3));
        chk("hold_level", 32'(level), 1);

        // Overflow: 10 changes into 8 entries
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            set_cur(8'(i));
            tick();
        end
        chk("ovf_level", 32'(level), 8);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_drop", 32'(drop_cnt), 2);
        ev_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_data%0d", i), 32'(ev_data), 32'(i));
            chk($sformatf("drain_ts%0d", i), 32'(ev_ts), ts_exp(i - 1));
            tick();
        end
        chk("drain_valid", 32'(ev_valid), 0);
        chk("drain_level", 32'(level), 0);
        chk("drain_empty_data", 32'(ev_data), 0);

        // Full with simultaneous pop and push
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_cur(8'h11 + 8'(i));
            tick();
        end
        chk("full_level", 32'(level), 8);
        ev_ready = 1'b1;
        set_cur(8'h19);
        tick();
        ev_ready = 1'b0;
        chk("pp_level", 32'(level), 8);
        chk("pp_ovf", 32'(ovf), 1);
        chk("pp_drop", 32'(drop_cnt), 2);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_data%0d", i), 32'(ev_data), 32'h12 + 32'(i));
            tick();
        end
        chk("pp_empty", 32'(ev_valid), 0);
        ev_ready = 1'b0;

        // Reset flushes queued events
        for (int i = 0; i < 3; i++) begin
            set_cur(8'h21 + 8'(i));
            tick();
        end
        chk("q3_level", 32'(level), 3);
        do_reset();
        chk("flush_level", 32'(level), 0);
        chk("flush_valid", 32'(ev_valid), 0);
        chk("flush_ovf", 32'(ovf), 0);
        chk("flush_drop", 32'(drop_cnt), 0);
        set_cur(8'h00);
        tick();
        chk("post_rst_nochg", 32'(level), 0);
        set_cur(8'h05);
        tick();
        chk("post_rst_valid", 32'(ev_valid), 1);
        chk("post_rst_data", 32'(ev_data), 32'h05);
        chk("post_rst_ts", 32'(ev_ts), ts_exp(1));

        // en=0 freezes prev; re-enable compares against frozen value
        en = 1'b0;
        set_cur(8'h06);
        repeat (2) tick();
        chk("dis_level", 32'(level), 1);
        en = 1'b1;
        tick();
        chk("reen_level", 32'(level), 2);

        // ovf_clr collides with a drop, then clears cleanly
        do_reset();
        for (int i = 0; i < 13; i++) begin
            set_cur(8'h31 + 8'(i));
            tick();
        end
        chk("d5_drop", 32'(drop_cnt), 5);
        chk("d5_ovf", 32'(ovf), 1);
        ovf_clr = 1'b1;
        set_cur(8'h3E);
        tick();
        chk("clr_drop_ovf", 32'(ovf), 1);
        chk("clr_drop_cnt", 32'(drop_cnt), 1);
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_cnt", 32'(drop_cnt), 0);
        chk("clr_level", 32'(level), 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
